// File: rtl/button_updown_counter_if.sv
// Pushbutton inputs and BCD/7-segment outputs of button_updown_counter.
// The board or bench drives the master side; the counter uses the slave side.
interface button_updown_counter_if #(
  parameter int N_DIGITS = 2
);
  logic                  i_Switch_1;
  logic                  i_Switch_2;
  logic [4*N_DIGITS-1:0] o_Count;
  logic [7*N_DIGITS-1:0] o_Segments;
  logic                  o_Wrap;

  modport master (
    output i_Switch_1, i_Switch_2,
    input  o_Count, o_Segments, o_Wrap
  );

  modport slave (
    input  i_Switch_1, i_Switch_2,
    output o_Count, o_Segments, o_Wrap
  );
endinterface

// File: rtl/button_updown_counter.sv
// Debounced UP/DOWN pushbuttons step an N_DIGITS BCD counter shown on 7-segment displays.
// Optional auto-repeat while one button is held: define BUTTON_COUNTER_REPEAT_EN.
module button_updown_counter #(
    parameter int DEBOUNCE_TIME = 250_000,
    parameter int N_DIGITS      = 2,
    parameter int REPEAT_DELAY  = 12_500_000,
    parameter int REPEAT_PERIOD = 2_500_000
) (
    input logic i_Clk,
    input logic i_Rst_L,
    button_updown_counter_if.slave bus
);

    localparam int DW = $clog2(DEBOUNCE_TIME + 1);
    localparam int CW = 4 * N_DIGITS;
    localparam int SW = 7 * N_DIGITS;

    if (N_DIGITS < 1 || N_DIGITS > 4 || DEBOUNCE_TIME < 2 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("button_updown_counter: parameter out of range");
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // bit 0 = UP (Switch_1), bit 1 = DOWN (Switch_2)
    logic [1:0]    sync_a, sync_b, deb, deb_q, rise;
    logic [DW-1:0] db_cnt [2];
    logic          up_evt, dn_evt, step_up, step_dn;
    logic [CW-1:0] count, count_nxt;
    logic [SW-1:0] segs;
    logic          wrap, wrap_nxt;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_a <= '0;
            sync_b <= '0;
            deb    <= '0;
            deb_q  <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync_a <= {bus.i_Switch_2, bus.i_Switch_1};
            sync_b <= sync_a;
            deb_q  <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] != deb[i]) begin
                    if (db_cnt[i] == DW'(DEBOUNCE_TIME - 1)) begin
                        deb[i]    <= sync_b[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Press edges only; a same-cycle UP+DOWN pair cancels out.
    assign rise   = deb & ~deb_q;
    assign up_evt = rise[0] & ~rise[1];
    assign dn_evt = rise[1] & ~rise[0];

`ifdef BUTTON_COUNTER_REPEAT_EN
    logic [31:0] hold_cnt, rep_limit;
    logic        in_repeat, held_one, rep_fire;

    assign held_one  = deb[0] ^ deb[1];
    assign rep_limit = in_repeat ? 32'(REPEAT_PERIOD - 1) : 32'(REPEAT_DELAY - 1);
    assign rep_fire  = held_one && (rise == 2'b00) && (hold_cnt == rep_limit);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            hold_cnt  <= '0;
            in_repeat <= 1'b0;
        end else if (!held_one || (rise != 2'b00)) begin
            hold_cnt  <= '0;
            in_repeat <= 1'b0;
        end else if (rep_fire) begin
            hold_cnt  <= '0;
            in_repeat <= 1'b1;
        end else begin
            hold_cnt  <= hold_cnt + 32'd1;
        end
    end

    assign step_up = up_evt | (rep_fire & deb[0]);
    assign step_dn = dn_evt | (rep_fire & deb[1]);
`else
    assign step_up = up_evt;
    assign step_dn = dn_evt;
`endif

    // BCD ripple: carry/borrow surviving past the top digit is the wrap.
    always_comb begin
        logic cy;
        count_nxt = count;
        wrap_nxt  = 1'b0;
        cy        = 1'b1;
        if (step_up) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if (cy) begin
                    if (count[i*4 +: 4] == 4'd9) begin
                        count_nxt[i*4 +: 4] = 4'd0;
                    end else begin
                        count_nxt[i*4 +: 4] = count[i*4 +: 4] + 4'd1;
                        cy = 1'b0;
                    end
                end
            end
            wrap_nxt = cy;
        end else if (step_dn) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if (cy) begin
                    if (count[i*4 +: 4] == 4'd0) begin
                        count_nxt[i*4 +: 4] = 4'd9;
                    end else begin
                        count_nxt[i*4 +: 4] = count[i*4 +: 4] - 4'd1;
                        cy = 1'b0;
                    end
                end
            end
            wrap_nxt = cy;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            count <= '0;
            wrap  <= 1'b0;
            segs  <= {N_DIGITS{7'b1000000}};
        end else begin
            count <= count_nxt;
            wrap  <= wrap_nxt;
            for (int i = 0; i < N_DIGITS; i++) segs[i*7 +: 7] <= seg7(count[i*4 +: 4]);
        end
    end

    assign bus.o_Count    = count;
    assign bus.o_Segments = segs;
    assign bus.o_Wrap     = wrap;

endmodule

// File: tb/tb_button_updown_counter.sv
// Directed bench for button_updown_counter (DEBOUNCE_TIME=4, N_DIGITS=2).
// Expected counts are hand-computed and queued in exp_q before each check.
module tb_button_updown_counter;

  localparam int N_DIGITS = 2;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   wrap_hi = 0;
  int   w0;
  logic [7:0] exp_q[$];
  logic [7:0] hold_exp;

  button_updown_counter_if #(.N_DIGITS(N_DIGITS)) sif ();

  button_updown_counter #(
    .DEBOUNCE_TIME(4),
    .N_DIGITS     (N_DIGITS),
    .REPEAT_DELAY (20),
    .REPEAT_PERIOD(8)
  ) dut (
    .i_Clk  (clk),
    .i_Rst_L(rst_n),
    .bus    (sif.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // counts every cycle o_Wrap is high, so a delta of 1 means a single-cycle pulse
  always @(negedge clk) if (sif.o_Wrap === 1'b1) wrap_hi++;

  // driver tasks (called just after a falling edge)
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit up, input bit dn, input int hold, input int gap);
    sif.i_Switch_1 = up;
    sif.i_Switch_2 = dn;
    tick(hold);
    sif.i_Switch_1 = 1'b0;
    sif.i_Switch_2 = 1'b0;
    tick(gap);
  endtask

  task automatic press_up(input int n);
    for (int i = 0; i < n; i++) press(1'b1, 1'b0, 10, 12);
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic check_count(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    check(tag, 32'(sif.o_Count), 32'(e));
  endtask

  initial begin
    rst_n = 1'b0;
    sif.i_Switch_1 = 1'b0;
    sif.i_Switch_2 = 1'b0;
    tick(3);
    exp_q.push_back(8'h00); check_count("count_in_reset");
    check("segs_in_reset", 32'(sif.o_Segments), 32'(14'b1000000_1000000));
    check("wrap_in_reset", 32'(sif.o_Wrap), 32'd0);
    rst_n = 1'b1;
    tick(2);
    exp_q.push_back(8'h00); check_count("count_after_reset");
    check("segs_after_reset", 32'(sif.o_Segments), 32'(14'b1000000_1000000));

    // latency: 2 sync + 4 debounce edges, count on the 7th edge, segments on the 8th
    w0 = wrap_hi;
    sif.i_Switch_1 = 1'b1;
    tick(6);
    exp_q.push_back(8'h00); check_count("count_before_step");
    tick(1);
    exp_q.push_back(8'h01); check_count("count_first_step");
    check("segs_lag_one_cycle", 32'(sif.o_Segments), 32'(14'b1000000_1000000));
    tick(1);
    check("segs_show_1", 32'(sif.o_Segments), 32'(14'b1000000_1111001));
    tick(2);
    sif.i_Switch_1 = 1'b0;
    tick(12);
    press_up(2);
    exp_q.push_back(8'h03); check_count("count_three_ups");
    check("segs_show_03", 32'(sif.o_Segments), 32'(14'b1000000_0110000));
    check("no_wrap_normal_steps", 32'(wrap_hi - w0), 32'd0);

    // 3-cycle glitch is shorter than the debounce time
    press(1'b1, 1'b0, 3, 12);
    exp_q.push_back(8'h03); check_count("glitch_rejected");

    press_up(6);
    exp_q.push_back(8'h09); check_count("count_09");
    press_up(1);
    exp_q.push_back(8'h10); check_count("carry_09_to_10");
    check("segs_show_10", 32'(sif.o_Segments), 32'(14'b1111001_1000000));
    press(1'b0, 1'b1, 10, 12);
    exp_q.push_back(8'h09); check_count("borrow_10_to_09");
    press_up(1);

    press_up(89);
    exp_q.push_back(8'h99); check_count("preload_99");
    check("segs_show_99", 32'(sif.o_Segments), 32'(14'b0010000_0010000));

    w0 = wrap_hi;
    press_up(1);
    exp_q.push_back(8'h00); check_count("wrap_up_99_to_00");
    check("wrap_up_single_pulse", 32'(wrap_hi - w0), 32'd1);

    w0 = wrap_hi;
    press(1'b0, 1'b1, 10, 12);
    exp_q.push_back(8'h99); check_count("wrap_down_00_to_99");
    check("wrap_down_single_pulse", 32'(wrap_hi - w0), 32'd1);

    w0 = wrap_hi;
    press(1'b1, 1'b1, 10, 12);
    exp_q.push_back(8'h99); check_count("both_pressed_discarded");
    check("both_pressed_no_wrap", 32'(wrap_hi - w0), 32'd0);

    press_up(1);
    exp_q.push_back(8'h00); check_count("back_to_00");

    // long hold: repeats at 20, 28, 36, 44 cycles after the step when enabled
`ifdef BUTTON_COUNTER_REPEAT_EN
    hold_exp = 8'h05;
`else
    hold_exp = 8'h01;
`endif
    press(1'b1, 1'b0, 50, 14);
    exp_q.push_back(hold_exp); check_count("long_hold");

    // reset while held; the still-held button must debounce again and step once
    sif.i_Switch_1 = 1'b1;
    tick(8);
    exp_q.push_back(hold_exp + 8'h01); check_count("step_before_reset");
    rst_n = 1'b0;
    tick(2);
    exp_q.push_back(8'h00); check_count("count_mid_hold_reset");
    check("segs_mid_hold_reset", 32'(sif.o_Segments), 32'(14'b1000000_1000000));
    rst_n = 1'b1;
    tick(9);
    sif.i_Switch_1 = 1'b0;
    tick(12);
    exp_q.push_back(8'h01); check_count("held_through_reset_steps");
    check("segs_after_reset_step", 32'(sif.o_Segments), 32'(14'b1000000_1111001));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
